// File: rtl/banco_registro_scan_if.sv
// -----------------------------------------------------------------------------
// banco_registro_scan_if
// Register bank bus: read/write addresses, write data, the raw write button,
// the scan enable and the read-back signals.
//
//   master : board side / testbench. Drives addresses, data, RegWrite and scan.
//            Receives datOutRa, datOutRb and scanAddr.
//   slave  : banco_registro_scan. The directions are the reverse of master.
// -----------------------------------------------------------------------------
interface banco_registro_scan_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] addrRa;
   logic [ADDR_W-1:0] addrRb;
   logic [ADDR_W-1:0] addrW;
   logic [DATA_W-1:0] datW;
   logic              RegWrite;
   logic              scan;
   logic [DATA_W-1:0] datOutRa;
   logic [DATA_W-1:0] datOutRb;
   logic [ADDR_W-1:0] scanAddr;

   modport master (
      output addrRa, addrRb, addrW, datW, RegWrite, scan,
      input  datOutRa, datOutRb, scanAddr
   );

   modport slave (
      input  addrRa, addrRb, addrW, datW, RegWrite, scan,
      output datOutRa, datOutRb, scanAddr
   );
endinterface

// File: rtl/banco_registro_scan.sv
// -----------------------------------------------------------------------------
// banco_registro_scan
// Register bank with 2**ADDR_W registers of DATA_W bits. It has two
// combinational read ports and one write port. The write strobe is a raw
// push-button, so one press gives exactly one write. The block also drives a
// multiplexed hex 7-segment display. Port A can step through all registers
// automatically when scan mode is on.
//
// Ports:
//   clk   : system clock
//   rst   : asynchronous reset, active-low
//   bus   : banco_registro_scan_if.slave. Carries addrRa, addrRb, addrW, datW,
//           RegWrite and scan in, and datOutRa, datOutRb and scanAddr out.
//   sseg  : segments a..g, active-low, sseg[0] = a
//   an    : digit enables, active-low. Digits 0..NDIG-1 show port A and the
//           remaining digits show port B, least significant nibble first.
//
// Optional feature:
//   ZERO_REG_EN : when defined, register 0 is hardwired to zero. Writes to
//                 address 0 are dropped and reads of address 0 return 0.
// -----------------------------------------------------------------------------
module banco_registro_scan #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 4,
   parameter int ADDR_INV    = 1,
   parameter int REFRESH_DIV = 50000,
   parameter int SCAN_DIV    = 25000000
) (
   input  logic                    clk,
   input  logic                    rst,
   banco_registro_scan_if.slave    bus,
   output logic [0:6]              sseg,
   output logic [2*DATA_W/4-1:0]   an
);

   localparam int NREG   = 2 ** ADDR_W;
   localparam int NDIG   = DATA_W / 4;
   localparam int NDIGT  = 2 * NDIG;
   localparam int IDX_W  = $clog2(NDIGT);
   localparam int REF_W  = $clog2(REFRESH_DIV);
   localparam int SCAN_W = $clog2(SCAN_DIV);

   localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NDIGT - 1);
   localparam logic [NDIGT-1:0]  AN_ONE    = NDIGT'(1);

   // ---------------------------------------------------------------------------
   // Button synchroniser and rising-edge detector
   // ---------------------------------------------------------------------------
   logic syncMeta;
   logic syncStable;
   logic syncPrev;
   logic wp;
   logic wrEn;

   // NOTE: every clocked block uses non-blocking assignments. All flops then
   // sample the values from before the edge, which keeps this shift chain a
   // real three-stage chain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         syncMeta   <= 1'b0;
         syncStable <= 1'b0;
         syncPrev   <= 1'b0;
      end else begin
         syncMeta   <= bus.RegWrite;
         syncStable <= syncMeta;
         syncPrev   <= syncStable;
      end
   end

   // Single-cycle pulse on the first cycle the synchronised button is high.
   // It fires on the 3rd clk edge after the raw button rises.
   assign wp = syncStable & ~syncPrev;

`ifdef ZERO_REG_EN
   assign wrEn = wp && (bus.addrW != '0);
`else
   assign wrEn = wp;
`endif

   // ---------------------------------------------------------------------------
   // Register storage
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] regs [NREG];

   // NOTE: the array sits on the async reset because every register must read
   // 0 after reset. This forces flops instead of a RAM macro, which is fine at
   // this depth.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wrEn) begin
         regs[bus.addrW] <= bus.datW;
      end
   end

   // ---------------------------------------------------------------------------
   // Auto-scan counter. It only advances while scan = 1. When scan drops, the
   // address keeps its value and the prescaler restarts from 0.
   // ---------------------------------------------------------------------------
   logic [SCAN_W-1:0] scanPre;
   logic [ADDR_W-1:0] scanCnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scanPre <= '0;
         scanCnt <= '0;
      end else if (!bus.scan) begin
         scanPre <= '0;
      end else if (scanPre == SCAN_LAST) begin
         scanPre <= '0;
         scanCnt <= scanCnt + ADDR_W'(1);
      end else begin
         scanPre <= scanPre + SCAN_W'(1);
      end
   end

   assign bus.scanAddr = scanCnt;

   // ---------------------------------------------------------------------------
   // Read ports. These are combinational, so a read of the address being
   // written returns the stored value until the write edge has passed.
   // ---------------------------------------------------------------------------
   logic [ADDR_W-1:0] swA;
   logic [ADDR_W-1:0] effA;
   logic [ADDR_W-1:0] effB;
   logic [DATA_W-1:0] datA;
   logic [DATA_W-1:0] datB;

   // NOTE: every signal driven here gets a value on every path, with a default
   // first, so no latch can be inferred.
   always_comb begin
      swA  = (ADDR_INV != 0) ? ~bus.addrRa : bus.addrRa;
      effB = (ADDR_INV != 0) ? ~bus.addrRb : bus.addrRb;
      effA = bus.scan ? scanCnt : swA;
      datA = regs[effA];
      datB = regs[effB];
`ifdef ZERO_REG_EN
      if (effA == '0) datA = '0;
      if (effB == '0) datB = '0;
`endif
   end

   assign bus.datOutRa = datA;
   assign bus.datOutRb = datB;

   // ---------------------------------------------------------------------------
   // Display multiplexer
   // ---------------------------------------------------------------------------
   function automatic logic [0:6] hexDecode(input logic [3:0] v);
      logic [0:6] s;
      unique case (v)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   logic [REF_W-1:0]    refCnt;
   logic [IDX_W-1:0]    digIdx;
   logic [2*DATA_W-1:0] digPair;
   logic [3:0]          digNib;

   // Port B sits above port A, so digit k picks nibble k of this vector.
   assign digPair = {datB, datA};
   assign digNib  = digPair[{digIdx, 2'b00} +: 4];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refCnt <= '0;
         digIdx <= '0;
         an     <= '1;
         sseg   <= 7'b1111111;
      end else begin
         an   <= ~(AN_ONE << digIdx);
         sseg <= hexDecode(digNib);
         if (refCnt == REF_LAST) begin
            refCnt <= '0;
            digIdx <= (digIdx == IDX_LAST) ? '0 : digIdx + IDX_W'(1);
         end else begin
            refCnt <= refCnt + REF_W'(1);
         end
      end
   end

endmodule

// File: doc/banco_registro_scan.md
Name: banco_registro_scan

Overview:
Parametrised register bank with two asynchronous read ports and one synchronous write port, plus a built-in multiplexed hex 7-segment driver.
- Write strobe comes from a raw push-button; it is synchronised and edge-detected, so one press equals exactly one write.
- Optional auto-scan mode steps read port A through every register in turn.
- Sits directly under the board top: switches and buttons in, sseg/an out.

Parameters:
DATA_W, 8, register width in bits; multiple of 4, range 4..16.
ADDR_W, 4, address width; register count = 2**ADDR_W.
ADDR_INV, 1, 1 = address switch inputs are active-low and are inverted internally.
REFRESH_DIV, 50000, clk cycles per displayed digit; must be ≥2.
SCAN_DIV, 25000000, clk cycles per auto-scan address step; must be ≥2.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
addrRa  input  ADDR_W  read address A (raw switches)
addrRb  input  ADDR_W  read address B (raw switches)
addrW  input  ADDR_W  write address
datW  input  DATA_W  write data
RegWrite  input  1  raw write button, active-high, asynchronous to clk
scan  input  1  1 = port A address comes from the internal scan counter
datOutRa  output  DATA_W  read data A
datOutRb  output  DATA_W  read data B
scanAddr  output  ADDR_W  current scan counter value
sseg  output  [0:6]  segments a..g, active-low, sseg[0] = a
an  output  2*DATA_W/4  digit enables, active-low

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers = 0; sync/edge flops = 0
  - refresh counter, digit index and scan counter = 0; scanAddr = 0
  - an = all ones; sseg = 7'b1111111 (blank)
- Write path:
  - RegWrite passes through a 2-FF synchroniser, then a rising-edge detector, producing a 1-cycle pulse wp.
  - Register addrW is loaded with datW at the clk edge where wp=1, i.e. the 3rd clk edge after RegWrite rises.
  - A held button gives no further writes; a new write requires release and re-press.
  - addrW and datW are sampled at that edge and are not inverted.
- Read path:
  - Combinational: datOutRa = reg[effA], datOutRb = reg[effB].
  - effB = ADDR_INV ? ~addrRb : addrRb.
  - effA = scan ? scanAddr : (ADDR_INV ? ~addrRa : addrRa).
  - Read of the address being written in the same cycle returns the old value; the new value is visible the following cycle.
- Scan counter:
  - Counts only while scan=1; a prescaler counts 0..SCAN_DIV-1.
  - At terminal count, scanAddr increments, wrapping 2**ADDR_W-1 → 0.
  - scan=0 holds the prescaler at 0 and freezes scanAddr at its value (no clear).
- Display:
  - NDIG = DATA_W/4.
  - Refresh counter counts 0..REFRESH_DIV-1; at terminal count the digit index advances 0..2*NDIG-1, then wraps to 0.
  - Digit k < NDIG shows nibble k of datOutRa; digit k ≥ NDIG shows nibble k-NDIG of datOutRb (nibble 0 = LSB).
  - an and sseg are registered and update every cycle from the current index and data.
  - an = ~(1<<index); exactly one an bit is low from the first edge after reset release.
- Hex decode, active-low [a..g]: 0=0000001, 1=1001111, 5=0100100, 8=0000000, A=0001000, F=0111000; all 16 values are decoded.
- Reset mid-operation: all state clears immediately; a pending write pulse is discarded.

Optional Feature:
Macro ZERO_REG_EN.
- Defined: register 0 is hardwired to 0; writes to address 0 are ignored; any read of address 0 returns 0.
- Undefined: register 0 is an ordinary storage register.

Test Plan:
(Parameters: DATA_W=8, ADDR_W=4, REFRESH_DIV=4, SCAN_DIV=8, ADDR_INV=0.)
- Reset then release; read all 16 addresses -> all datOut = 0x00; an = 4'b1110 after the first edge; sseg = 0000001.
- datW=0xA5, addrW=3, pulse RegWrite high for 10 cycles, addrRa=3 -> reg3 written once on the 3rd edge; datOutRa=0xA5; digit0 sseg=0100100, digit1 sseg=0001000.
- Hold RegWrite high, change datW to 0x11 mid-press -> no second write; reg3 stays 0xA5.
- Write 0x0F to addr 5, scan=1 for 8*17 cycles -> scanAddr steps every 8 cycles, wraps 15 → 0; datOutRa=0x0F while scanAddr=5.
- Observe 16 cycles -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles, then repeats.
- ZERO_REG_EN defined, write 0xFF to addr 0 -> datOutRa(addr 0)=0x00; same write with the macro undefined -> 0xFF.
